// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable oversampling UART receiver
// 3-sample majority per bit, one-entry valid/ready holding register
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 10_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 break_detect
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_BRK
  } state_t;

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_A      = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_B      = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_C      = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] B_LAST   = BW'(DATA_BITS - 1);

  logic r_sync1, r_sync2, r_sync3;
  logic [DW-1:0] r_div;
  logic [SW-1:0] r_smp;
  logic [BW-1:0] r_bit;
  logic r_stop2, r_s0, r_s1, r_par, r_fe;
  logic [DATA_BITS-1:0] r_shift;
  state_t r_state, w_next;

  logic [DATA_BITS-1:0] r_data;
  logic r_valid, r_pe, r_fe_o, r_ovr, r_brk;

  logic w_restart, w_done;
  logic w_tick, w_dec, w_wrap, w_maj, w_fall;
  logic w_exp, w_pe, w_fe, w_brk, w_hs, w_last;

  // two-flop synchroniser plus one delayed copy for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_fall = r_sync3 & ~r_sync2;
  assign w_tick = (r_div == DIV_LAST);
  assign w_dec  = w_tick && (r_smp == S_C);
  assign w_wrap = w_tick && (r_smp == S_LAST);
  assign w_maj  = (r_s0 & r_s1) | (r_s0 & r_sync2) |
                  (r_s1 & r_sync2);
  assign w_exp  = (PARITY == 2) ? ^r_shift : ~^r_shift;
  assign w_pe   = (PARITY != 0) && (r_par != w_exp);
  assign w_fe   = r_fe | ~w_maj;
  assign w_brk  = ~r_stop2 & ~w_maj & ~r_par &
                  (r_shift == '0);
  assign w_last = r_stop2 | (STOP_BITS == 1);
  assign w_hs   = r_valid & data_ready;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next state, counter restart and frame completion
  always_comb begin
    w_next    = r_state;
    w_restart = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_next    = S_START;
          w_restart = 1'b1;
        end
      end
      S_START: begin
        if (w_dec && w_maj) w_next = S_IDLE;
        else if (w_wrap)    w_next = S_DATA;
      end
      S_DATA: begin
        if (w_wrap && (r_bit == B_LAST))
          w_next = (PARITY != 0) ? S_PAR : S_STOP;
      end
      S_PAR: begin
        if (w_wrap) w_next = S_STOP;
      end
      S_STOP: begin
        if (w_dec) begin
          if (w_brk) begin
            w_next = S_BRK;
            w_done = 1'b1;
          end else if (w_last) begin
            w_next = S_IDLE;
            w_done = 1'b1;
          end
        end
      end
      S_BRK: begin
        if (r_sync2) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // tick/sample counters, sampling and frame assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_smp   <= '0;
      r_bit   <= '0;
      r_stop2 <= 1'b0;
      r_s0    <= 1'b0;
      r_s1    <= 1'b0;
      r_par   <= 1'b0;
      r_fe    <= 1'b0;
      r_shift <= '0;
    end else if (w_restart) begin
      r_div   <= '0;
      r_smp   <= '0;
      r_bit   <= '0;
      r_stop2 <= 1'b0;
      r_par   <= 1'b0;
      r_fe    <= 1'b0;
      r_shift <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        r_smp <= (r_smp == S_LAST) ? '0 : r_smp + 1'b1;
        if (r_smp == S_A) r_s0 <= r_sync2;
        if (r_smp == S_B) r_s1 <= r_sync2;
      end
      if (w_dec) begin
        if (r_state == S_DATA)
          r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
        if (r_state == S_PAR)  r_par <= w_maj;
        if (r_state == S_STOP) r_fe  <= w_fe;
      end
      if (w_wrap) begin
        if (r_state == S_DATA) r_bit   <= r_bit + 1'b1;
        if (r_state == S_STOP) r_stop2 <= 1'b1;
      end
    end
  end

  // holding register with overrun on a full, unaccepted slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_pe    <= 1'b0;
      r_fe_o  <= 1'b0;
      r_ovr   <= 1'b0;
      r_brk   <= 1'b0;
    end else if (w_done && (!r_valid || data_ready)) begin
      r_data  <= r_shift;
      r_valid <= 1'b1;
      r_pe    <= w_pe;
      r_fe_o  <= w_fe;
      r_ovr   <= 1'b0;
      r_brk   <= w_brk;
    end else if (w_done) begin
      r_ovr   <= 1'b1;
    end else if (w_hs) begin
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

  assign data_out      = r_data;
  assign data_valid    = r_valid;
  assign parity_error  = r_pe;
  assign framing_error = r_fe_o;
  assign overrun_error = r_ovr;
  assign break_detect  = r_brk;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: bench for uart_rx_cfg
// four configurations, frame-level reference model
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rx_l;
  logic [3:0] rdy;
  logic [3:0] rstn;
  wire  [7:0] d0, d1, d2;
  wire  [6:0] d3;
  wire  [3:0] vld, pe, fe, ovr, brk;

  int errs = 0;
  int checks = 0;

  typedef struct {
    int         idx;
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       brk;
  } rec_t;

  rec_t obs[$];

  uart_rx_cfg u0 (
    .clk(clk), .rst_n(rstn[0]), .rx(rx_l[0]),
    .data_out(d0), .data_valid(vld[0]),
    .data_ready(rdy[0]), .parity_error(pe[0]),
    .framing_error(fe[0]), .overrun_error(ovr[0]),
    .break_detect(brk[0])
  );

  uart_rx_cfg #(
    .CLK_FREQ(3_200_000), .BAUD_RATE(100_000),
    .OVERSAMPLE(8)
  ) u1 (
    .clk(clk), .rst_n(rstn[1]), .rx(rx_l[1]),
    .data_out(d1), .data_valid(vld[1]),
    .data_ready(rdy[1]), .parity_error(pe[1]),
    .framing_error(fe[1]), .overrun_error(ovr[1]),
    .break_detect(brk[1])
  );

  uart_rx_cfg #(
    .CLK_FREQ(3_200_000), .BAUD_RATE(100_000),
    .OVERSAMPLE(8), .PARITY(2)
  ) u2 (
    .clk(clk), .rst_n(rstn[2]), .rx(rx_l[2]),
    .data_out(d2), .data_valid(vld[2]),
    .data_ready(rdy[2]), .parity_error(pe[2]),
    .framing_error(fe[2]), .overrun_error(ovr[2]),
    .break_detect(brk[2])
  );

  uart_rx_cfg #(
    .CLK_FREQ(3_200_000), .BAUD_RATE(100_000),
    .OVERSAMPLE(8), .DATA_BITS(7), .PARITY(1),
    .STOP_BITS(2)
  ) u3 (
    .clk(clk), .rst_n(rstn[3]), .rx(rx_l[3]),
    .data_out(d3), .data_valid(vld[3]),
    .data_ready(rdy[3]), .parity_error(pe[3]),
    .framing_error(fe[3]), .overrun_error(ovr[3]),
    .break_detect(brk[3])
  );

  function automatic int nb(input int i);
    return (i == 3) ? 7 : 8;
  endfunction

  function automatic int par(input int i);
    return (i == 2) ? 2 : (i == 3) ? 1 : 0;
  endfunction

  function automatic int sb(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  function automatic int bt(input int i);
    return (i == 0) ? 1040 : 32;
  endfunction

  function automatic logic [8:0] dat(input int i);
    case (i)
      0:       return {1'b0, d0};
      1:       return {1'b0, d1};
      2:       return {1'b0, d2};
      default: return {2'b0, d3};
    endcase
  endfunction

  // record every accepted frame (valid && ready before the edge)
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rstn[i] && vld[i] && rdy[i]) begin
        rec_t r;
        r.idx = i;
        r.d   = dat(i);
        r.pe  = pe[i];
        r.fe  = fe[i];
        r.brk = brk[i];
        obs.push_back(r);
      end
    end
  end

  // frame-level expectation from the line contents
  function automatic rec_t model(input int i, input logic [8:0] d,
                                 input logic pb, input logic s0,
                                 input logic s1);
    rec_t r;
    logic [8:0] m;
    int ones;
    m = d & ((9'h1 << nb(i)) - 9'h1);
    ones = $countones(m) + int'(pb);
    r.idx = i;
    r.d = m;
    if (par(i) == 0)      r.pe = 1'b0;
    else if (par(i) == 2) r.pe = (ones % 2) != 0;
    else                  r.pe = (ones % 2) != 1;
    r.brk = (m == 0) && (par(i) == 0 || !pb) && !s0;
    r.fe = r.brk || !s0 || (sb(i) == 2 && !s1);
    return r;
  endfunction

  task automatic send_frame(input int i, input logic [8:0] d,
                            input logic pb, input logic s0,
                            input logic s1);
    logic [15:0] b;
    int n;
    b = '1;
    n = 0;
    b[n] = 1'b0; n++;
    for (int k = 0; k < nb(i); k++) begin
      b[n] = d[k]; n++;
    end
    if (par(i) != 0) begin
      b[n] = pb; n++;
    end
    b[n] = s0; n++;
    if (sb(i) == 2) begin
      b[n] = s1; n++;
    end
    for (int k = 0; k < n; k++) begin
      rx_l[i] = b[k];
      repeat (bt(i)) @(negedge clk);
    end
    rx_l[i] = 1'b1;
    repeat (2 * bt(i)) @(negedge clk);
  endtask

  task automatic wait_pop(input int lim, output logic got,
                          output rec_t r);
    got = 1'b0;
    r = '{default: 0};
    for (int k = 0; k < lim && !got; k++) begin
      if (obs.size() > 0) begin
        r = obs.pop_front();
        got = 1'b1;
      end else begin
        @(negedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset();
    rx_l = '1;
    rdy = '1;
    rstn = '1;
    #2 rstn = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({vld, pe, fe, ovr, brk} !== 20'h0 ||
        {d0, d1, d2, d3} !== 31'h0) begin
      errs++;
      $display("FAIL reset: flags=%h data=%h, expected 0",
               {vld, pe, fe, ovr, brk}, {d0, d1, d2, d3});
    end
    rstn = '1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    rec_t r, e;
    logic got;
    send_frame(0, 9'h0A5, 1'b0, 1'b1, 1'b1);
    e = model(0, 9'h0A5, 1'b0, 1'b1, 1'b1);
    wait_pop(100, got, r);
    checks++;
    if (!got || r.idx != 0 || r.d !== e.d || r.pe !== e.pe ||
        r.fe !== e.fe || r.brk !== e.brk) begin
      errs++;
      $display("FAIL basic_A5: got=%0b d=%h pe=%b fe=%b brk=%b, expected d=%h pe=%b fe=%b brk=%b",
               got, r.d, r.pe, r.fe, r.brk, e.d, e.pe, e.fe, e.brk);
    end
    @(negedge clk); #1;
    checks++;
    if (vld[0] !== 1'b0 || obs.size() != 0 || ovr[0] !== 1'b0) begin
      errs++;
      $display("FAIL basic_pulse: valid=%b extra=%0d ovr=%b, expected 0 0 0",
               vld[0], obs.size(), ovr[0]);
    end
  endtask

  task automatic test_parity();
    rec_t r, e;
    logic got;
    for (int k = 0; k < 2; k++) begin
      logic pb;
      pb = (k == 0);
      send_frame(2, 9'h03C, pb, 1'b1, 1'b1);
      e = model(2, 9'h03C, pb, 1'b1, 1'b1);
      wait_pop(100, got, r);
      checks++;
      if (!got || r.idx != 2 || r.d !== e.d || r.pe !== e.pe ||
          r.fe !== e.fe || r.brk !== e.brk) begin
        errs++;
        $display("FAIL parity_3C[pb=%0b]: got=%0b d=%h pe=%b fe=%b, expected d=%h pe=%b fe=%b",
                 pb, got, r.d, r.pe, r.fe, e.d, e.pe, e.fe);
      end
    end
  endtask

  task automatic test_framing();
    rec_t r, e;
    logic got;
    send_frame(1, 9'h055, 1'b0, 1'b0, 1'b1);
    e = model(1, 9'h055, 1'b0, 1'b0, 1'b1);
    wait_pop(100, got, r);
    checks++;
    if (!got || r.d !== e.d || r.fe !== 1'b1 ||
        r.brk !== 1'b0 || r.pe !== 1'b0) begin
      errs++;
      $display("FAIL framing_55: got=%0b d=%h fe=%b brk=%b, expected d=%h fe=1 brk=0",
               got, r.d, r.fe, r.brk, e.d);
    end
    send_frame(1, 9'h00F, 1'b0, 1'b1, 1'b1);
    e = model(1, 9'h00F, 1'b0, 1'b1, 1'b1);
    wait_pop(100, got, r);
    checks++;
    if (!got || r.d !== e.d || r.fe !== e.fe ||
        r.brk !== e.brk || r.pe !== e.pe) begin
      errs++;
      $display("FAIL framing_next_0F: got=%0b d=%h fe=%b brk=%b, expected d=%h fe=0 brk=0",
               got, r.d, r.fe, r.brk, e.d);
    end
  endtask

  task automatic test_overrun();
    rec_t r;
    logic got;
    rdy[1] = 1'b0;
    send_frame(1, 9'h011, 1'b0, 1'b1, 1'b1);
    #1;
    checks++;
    if (vld[1] !== 1'b1 || d1 !== 8'h11 || ovr[1] !== 1'b0) begin
      errs++;
      $display("FAIL overrun_first: valid=%b d=%h ovr=%b, expected 1 11 0",
               vld[1], d1, ovr[1]);
    end
    send_frame(1, 9'h022, 1'b0, 1'b1, 1'b1);
    #1;
    checks++;
    if (vld[1] !== 1'b1 || d1 !== 8'h11 || ovr[1] !== 1'b1 ||
        obs.size() != 0) begin
      errs++;
      $display("FAIL overrun_hold: valid=%b d=%h ovr=%b seen=%0d, expected 1 11 1 0",
               vld[1], d1, ovr[1], obs.size());
    end
    @(posedge clk); #1 rdy[1] = 1'b1;
    @(posedge clk); #1 rdy[1] = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (vld[1] !== 1'b0 || ovr[1] !== 1'b0) begin
      errs++;
      $display("FAIL overrun_clear: valid=%b ovr=%b, expected 0 0",
               vld[1], ovr[1]);
    end
    wait_pop(10, got, r);
    repeat (3 * 32) @(negedge clk);
    #1;
    checks++;
    if (!got || r.d !== 9'h011 || obs.size() != 0 ||
        vld[1] !== 1'b0) begin
      errs++;
      $display("FAIL overrun_deliver: got=%0b d=%h extra=%0d valid=%b, expected 1 011 0 0",
               got, r.d, obs.size(), vld[1]);
    end
    rdy[1] = 1'b1;
  endtask

  task automatic test_glitch();
    rec_t r, e;
    logic got;
    rx_l[0] = 1'b0;
    repeat (300) @(negedge clk);
    rx_l[0] = 1'b1;
    repeat (2 * 1040) @(negedge clk);
    #1;
    checks++;
    if (obs.size() != 0 || vld[0] !== 1'b0) begin
      errs++;
      $display("FAIL glitch_none: frames=%0d valid=%b, expected 0 0",
               obs.size(), vld[0]);
    end
    send_frame(0, 9'h0C3, 1'b0, 1'b1, 1'b1);
    e = model(0, 9'h0C3, 1'b0, 1'b1, 1'b1);
    wait_pop(100, got, r);
    checks++;
    if (!got || r.d !== e.d || r.fe !== e.fe || r.pe !== e.pe ||
        r.brk !== e.brk) begin
      errs++;
      $display("FAIL glitch_C3: got=%0b d=%h fe=%b, expected d=%h fe=0",
               got, r.d, r.fe, e.d);
    end
  endtask

  task automatic test_data7();
    rec_t r, e;
    logic got;
    logic pb;
    pb = ($countones(9'h05A) % 2) == 0;
    for (int k = 0; k < 2; k++) begin
      logic s1;
      s1 = (k == 0);
      send_frame(3, 9'h05A, pb, 1'b1, s1);
      e = model(3, 9'h05A, pb, 1'b1, s1);
      wait_pop(100, got, r);
      checks++;
      if (!got || r.idx != 3 || r.d !== e.d || r.pe !== e.pe ||
          r.fe !== e.fe || r.brk !== e.brk) begin
        errs++;
        $display("FAIL data7_5A[s1=%0b]: got=%0b d=%h pe=%b fe=%b, expected d=%h pe=%b fe=%b",
                 s1, got, r.d, r.pe, r.fe, e.d, e.pe, e.fe);
      end
    end
  endtask

  task automatic test_break();
    rec_t r, e;
    logic got;
    rx_l[1] = 1'b0;
    repeat (12 * 32) @(negedge clk);
    #1;
    checks++;
    if (obs.size() != 1) begin
      errs++;
      $display("FAIL break_count: frames=%0d, expected 1",
               obs.size());
    end
    rx_l[1] = 1'b1;
    repeat (2 * 32) @(negedge clk);
    e = model(1, 9'h000, 1'b0, 1'b0, 1'b0);
    wait_pop(10, got, r);
    checks++;
    if (!got || r.d !== 9'h000 || r.brk !== 1'b1 ||
        r.fe !== 1'b1 || r.brk !== e.brk || obs.size() != 0) begin
      errs++;
      $display("FAIL break_frame: got=%0b d=%h brk=%b fe=%b extra=%0d, expected 000 1 1 0",
               got, r.d, r.brk, r.fe, obs.size());
    end
    send_frame(1, 9'h081, 1'b0, 1'b1, 1'b1);
    wait_pop(100, got, r);
    checks++;
    if (!got || r.d !== 9'h081 || r.brk !== 1'b0 ||
        r.fe !== 1'b0) begin
      errs++;
      $display("FAIL break_recover: got=%0b d=%h brk=%b fe=%b, expected 081 0 0",
               got, r.d, r.brk, r.fe);
    end
  endtask

  task automatic test_reset_mid();
    rec_t r, e;
    logic got;
    logic [7:0] a5;
    a5 = 8'hA5;
    for (int k = 0; k < 5; k++) begin
      rx_l[1] = (k == 0) ? 1'b0 : a5[k-1];
      repeat (32) @(negedge clk);
    end
    rstn[1] = 1'b0;
    rx_l[1] = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (d1 !== 8'h00 || vld[1] !== 1'b0 || pe[1] !== 1'b0 ||
        fe[1] !== 1'b0 || ovr[1] !== 1'b0 || brk[1] !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid: d=%h v=%b pe=%b fe=%b ovr=%b brk=%b, expected all 0",
               d1, vld[1], pe[1], fe[1], ovr[1], brk[1]);
    end
    rstn[1] = 1'b1;
    repeat (12 * 32) @(negedge clk);
    #1;
    checks++;
    if (obs.size() != 0 || vld[1] !== 1'b0) begin
      errs++;
      $display("FAIL reset_quiet: frames=%0d valid=%b, expected 0 0",
               obs.size(), vld[1]);
    end
    send_frame(1, 9'h096, 1'b0, 1'b1, 1'b1);
    e = model(1, 9'h096, 1'b0, 1'b1, 1'b1);
    wait_pop(100, got, r);
    checks++;
    if (!got || r.d !== e.d || r.fe !== e.fe || r.pe !== e.pe ||
        r.brk !== e.brk) begin
      errs++;
      $display("FAIL reset_96: got=%0b d=%h fe=%b, expected d=%h fe=0",
               got, r.d, r.fe, e.d);
    end
  endtask

  task automatic test_random();
    rec_t r, e;
    logic got;
    for (int k = 0; k < 24; k++) begin
      int i;
      logic [8:0] d;
      logic pb, s0, s1;
      i  = 1 + int'($urandom_range(0, 2));
      d  = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 7) == 0) d = '0;
      pb = 1'($urandom_range(0, 1));
      s0 = ($urandom_range(0, 4) != 0);
      s1 = ($urandom_range(0, 4) != 0);
      send_frame(i, d, pb, s0, s1);
      e = model(i, d, pb, s0, s1);
      wait_pop(100, got, r);
      checks++;
      if (!got || r.idx != i || r.d !== e.d || r.pe !== e.pe ||
          r.fe !== e.fe || r.brk !== e.brk) begin
        errs++;
        $display("FAIL rand[%0d] u%0d: got=%0b d=%h pe=%b fe=%b brk=%b, expected d=%h pe=%b fe=%b brk=%b",
                 k, i, got, r.d, r.pe, r.fe, r.brk,
                 e.d, e.pe, e.fe, e.brk);
      end
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_overrun();
    test_glitch();
    test_data7();
    test_break();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
